// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and helpers for the register-file write-port arbiter
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;

  typedef enum logic {NORMAL, FORCE} arb_state_t;

  typedef logic [4:0] reg_addr_t;

  // x0 of the integer file is hardwired: writes to it are consumed but dropped
  function automatic logic drop_write(input logic fp_file, input reg_addr_t addr);
    return !fp_file && (addr == '0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy tracking for registers awaiting a multi-cycle result
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int FP_TYPE  = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      issue_valid,
  input  reg_addr_t issue_addr,
  output logic      issue_ready,
  input  logic      clr_valid,
  input  reg_addr_t clr_addr,
  input  reg_addr_t chk_addr1,
  input  reg_addr_t chk_addr2,
  output logic      chk_busy1,
  output logic      chk_busy2
);

  localparam int   REG_SPACE = 1 << RF_ADDR_W;
  localparam logic FP_FILE   = (FP_TYPE != 0);

  // Registers that can ever become busy: inside the file and not the hardwired x0
  function automatic logic [REG_SPACE-1:0] valid_mask();
    logic [REG_SPACE-1:0] m;
    for (int i = 0; i < REG_SPACE; i++) begin
      m[i] = (i < NUM_REGS) && !(!FP_FILE && i == 0);
    end
    return m;
  endfunction

  localparam logic [REG_SPACE-1:0] VALID_MASK = valid_mask();

  logic [REG_SPACE-1:0] busy;
  logic [REG_SPACE-1:0] set_vec;
  logic [REG_SPACE-1:0] clr_vec;

  assign issue_ready = ~busy[issue_addr] | drop_write(FP_FILE, issue_addr);

  // No bypass: a register clearing this cycle still reads busy until the edge
  assign chk_busy1 = busy[chk_addr1];
  assign chk_busy2 = busy[chk_addr2];

  // One-hot set/clear requests from the issue and completion handshakes
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_ready) set_vec[issue_addr] = 1'b1;
    if (clr_valid) clr_vec[clr_addr] = 1'b1;
  end

  // Busy vector update; set and clear of different registers both apply
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= ((busy | set_vec) & ~clr_vec) & VALID_MASK;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between pipeline and multi-cycle unit
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int WIDTH        = 32,
  parameter int FP_TYPE      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pipe_wb_valid,
  input  logic [4:0]       pipe_wb_addr,
  input  logic [WIDTH-1:0] pipe_wb_data,
  output logic             pipe_stall,
  input  logic             mc_valid,
  input  logic [4:0]       mc_addr,
  input  logic [WIDTH-1:0] mc_data,
  output logic             mc_ready,
  input  logic             issue_valid,
  input  logic [4:0]       issue_addr,
  output logic             issue_ready,
  input  logic [4:0]       chk_addr1,
  input  logic [4:0]       chk_addr2,
  output logic             chk_busy1,
  output logic             chk_busy2,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata
);

  localparam int             CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic           FP_FILE  = (FP_TYPE != 0);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             pipe_fire;
  logic             mc_fire;
  logic             mc_denied;

  // Pipeline has priority except during the single forced cycle
  assign pipe_stall = (state == FORCE);
  assign mc_ready   = (state == FORCE) ? 1'b1 : ~pipe_wb_valid;
  assign pipe_fire  = (state == NORMAL) && pipe_wb_valid;
  assign mc_fire    = mc_valid && mc_ready;
  assign mc_denied  = mc_valid && !mc_ready;

  // Starvation counter and NORMAL/FORCE state; FORCE always lasts one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (mc_denied) begin
            starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
            if (starve_cnt == CNT_LAST) state <= FORCE;
          end else begin
            starve_cnt <= '0;
          end
        end
        FORCE: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
        default: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Register the granted write; dropped x0 writes and idle cycles hold addr/data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pipe_fire) begin
      rf_we <= !drop_write(FP_FILE, pipe_wb_addr);
      if (!drop_write(FP_FILE, pipe_wb_addr)) begin
        rf_waddr <= pipe_wb_addr;
        rf_wdata <= pipe_wb_data;
      end
    end else if (mc_fire) begin
      rf_we <= !drop_write(FP_FILE, mc_addr);
      if (!drop_write(FP_FILE, mc_addr)) begin
        rf_waddr <= mc_addr;
        rf_wdata <= mc_data;
      end
    end else begin
      rf_we <= 1'b0;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .FP_TYPE  (FP_TYPE)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .clr_valid   (mc_fire),
    .clr_addr    (mc_addr),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pv, mv, iv;
  logic [4:0]  pa, ma, ia, c1, c2;
  logic [31:0] pd, md;

  logic        pipe_stall, mc_ready, issue_ready, chk_busy1, chk_busy2, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        fp_pipe_stall, fp_mc_ready, fp_issue_ready, fp_chk_busy1, fp_chk_busy2, fp_rf_we;
  logic [4:0]  fp_rf_waddr;
  logic [31:0] fp_rf_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REGS(32), .WIDTH(32), .FP_TYPE(0), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_wb_valid(pv), .pipe_wb_addr(pa), .pipe_wb_data(pd), .pipe_stall(pipe_stall),
    .mc_valid(mv), .mc_addr(ma), .mc_data(md), .mc_ready(mc_ready),
    .issue_valid(iv), .issue_addr(ia), .issue_ready(issue_ready),
    .chk_addr1(c1), .chk_addr2(c2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  rf_wb_arbiter #(.NUM_REGS(32), .WIDTH(32), .FP_TYPE(1), .STARVE_LIMIT(4)) u_dut_fp (
    .clk(clk), .reset_n(reset_n),
    .pipe_wb_valid(pv), .pipe_wb_addr(pa), .pipe_wb_data(pd), .pipe_stall(fp_pipe_stall),
    .mc_valid(mv), .mc_addr(ma), .mc_data(md), .mc_ready(fp_mc_ready),
    .issue_valid(iv), .issue_addr(ia), .issue_ready(fp_issue_ready),
    .chk_addr1(c1), .chk_addr2(c2), .chk_busy1(fp_chk_busy1), .chk_busy2(fp_chk_busy2),
    .rf_we(fp_rf_we), .rf_waddr(fp_rf_waddr), .rf_wdata(fp_rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.we = we;
    e.a  = a;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic check_rf(input string tag);
    wr_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_qsize"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_we"}, 32'(rf_we), 32'(e.we));
      if (e.we) begin
        chk({tag, "_waddr"}, 32'(rf_waddr), 32'(e.a));
        chk({tag, "_wdata"}, rf_wdata, e.d);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    pv = 1'b0; mv = 1'b0; iv = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    pv = 1'b0; pa = '0; pd = '0;
    mv = 1'b0; ma = '0; md = '0;
    iv = 1'b0; ia = '0;
    c1 = 5'd7; c2 = 5'd8;

    // reset state
    tick();
    tick();
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_waddr", 32'(rf_waddr), 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_pipe_stall", 32'(pipe_stall), 0);
    chk("rst_chk_busy1", 32'(chk_busy1), 0);
    chk("rst_mc_ready", 32'(mc_ready), 1);
    reset_n = 1'b1;

    // plain pipe write
    pv = 1'b1; pa = 5'd5; pd = 32'hDEADBEEF;
    push_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_rf("pipe_wr");
    idle();
    push_wr(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("pipe_idle");
    chk("idle_waddr_hold", 32'(rf_waddr), 5);

    // x0 write: dropped in the integer file, written in the FP file
    pv = 1'b1; pa = 5'd0; pd = 32'h1234;
    push_wr(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("int_x0");
    chk("int_x0_waddr_hold", 32'(rf_waddr), 5);
    chk("fp_f0_we", 32'(fp_rf_we), 1);
    chk("fp_f0_waddr", 32'(fp_rf_waddr), 0);
    chk("fp_f0_wdata", fp_rf_wdata, 32'h1234);
    idle();

    // pipe/mc conflict
    pv = 1'b1; pa = 5'd3; pd = 32'h11;
    mv = 1'b1; ma = 5'd9; md = 32'h22;
    settle();
    chk("conflict_mc_ready0", 32'(mc_ready), 0);
    push_wr(1'b1, 5'd3, 32'h11);
    tick();
    check_rf("conflict_pipe_wr");
    pv = 1'b0;
    settle();
    chk("conflict_mc_ready1", 32'(mc_ready), 1);
    push_wr(1'b1, 5'd9, 32'h22);
    tick();
    check_rf("conflict_mc_wr");
    idle();

    // starvation forces one stall cycle
    pv = 1'b1; pa = 5'd1;
    mv = 1'b1; ma = 5'd12; md = 32'hCAFE;
    for (int i = 0; i < 4; i++) begin
      pd = 32'h100 + 32'(i);
      settle();
      chk("starve_mc_ready", 32'(mc_ready), 0);
      chk("starve_stall", 32'(pipe_stall), 0);
      push_wr(1'b1, 5'd1, pd);
      tick();
      check_rf("starve_pipe_wr");
    end
    pd = 32'h77;
    settle();
    chk("force_stall", 32'(pipe_stall), 1);
    chk("force_mc_ready", 32'(mc_ready), 1);
    push_wr(1'b1, 5'd12, 32'hCAFE);
    tick();
    check_rf("force_mc_wr");
    mv = 1'b0;
    settle();
    chk("post_force_stall", 32'(pipe_stall), 0);
    chk("post_force_cnt", 32'(u_dut.starve_cnt), 0);
    push_wr(1'b1, 5'd1, 32'h77);
    tick();
    check_rf("post_force_pipe_wr");
    idle();

    // scoreboard set, duplicate issue, simultaneous clear and set
    iv = 1'b1; ia = 5'd7;
    settle();
    chk("issue7_ready", 32'(issue_ready), 1);
    chk("issue7_busy_before", 32'(chk_busy1), 0);
    tick();
    settle();
    chk("issue7_busy_after", 32'(chk_busy1), 1);
    chk("issue7_dup_ready", 32'(issue_ready), 0);
    mv = 1'b1; ma = 5'd7; md = 32'h55;
    ia = 5'd8;
    settle();
    chk("clr7_no_bypass", 32'(chk_busy1), 1);
    chk("issue8_ready", 32'(issue_ready), 1);
    chk("busy8_before", 32'(chk_busy2), 0);
    push_wr(1'b1, 5'd7, 32'h55);
    tick();
    check_rf("mc7_wr");
    idle();
    settle();
    chk("busy7_cleared", 32'(chk_busy1), 0);
    chk("busy8_set", 32'(chk_busy2), 1);

    // reset in the middle of a forced cycle
    iv = 1'b1; ia = 5'd7;
    tick();
    iv = 1'b0;
    pv = 1'b1; pa = 5'd2;
    mv = 1'b1; ma = 5'd20; md = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      pd = 32'h200 + 32'(i);
      push_wr(1'b1, 5'd2, pd);
      tick();
      check_rf("pre_rst_pipe_wr");
    end
    chk("pre_rst_stall", 32'(pipe_stall), 1);
    chk("pre_rst_busy7", 32'(chk_busy1), 1);
    reset_n = 1'b0;
    settle();
    chk("mid_rst_stall", 32'(pipe_stall), 0);
    chk("mid_rst_rf_we", 32'(rf_we), 0);
    chk("mid_rst_waddr", 32'(rf_waddr), 0);
    chk("mid_rst_busy7", 32'(chk_busy1), 0);
    chk("mid_rst_busy8", 32'(chk_busy2), 0);
    idle();
    tick();
    reset_n = 1'b1;
    pv = 1'b1; pa = 5'd6; pd = 32'hA5A5;
    push_wr(1'b1, 5'd6, 32'hA5A5);
    tick();
    check_rf("after_rst_pipe_wr");
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
